ibex_mem_arbiter: RTL and testbench



---
 rtl/ibex_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ibex_mem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_arbiter.sv
// N-master to 1-slave req/gnt/rvalid arbiter: round-robin with request lock, in-order response routing FIFO.
// Latency: zero-cycle combinational request path and response path; state updates on clk_i.
// Backpressure: slave stalls via s_gnt_i (winner is locked); a full routing FIFO withholds s_req_o, so masters stay pending.
module ibex_mem_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  // master side
  input  logic [NUM_MASTERS-1:0]           m_req_i,
  output logic [NUM_MASTERS-1:0]           m_gnt_o,
  output logic [NUM_MASTERS-1:0]           m_rvalid_o,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]  m_be_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [DATA_WIDTH-1:0]            m_rdata_o,
  output logic                             m_err_o,
  // slave side
  output logic                             s_req_o,
  input  logic                             s_gnt_i,
  input  logic                             s_rvalid_i,
  output logic                             s_we_o,
  output logic [BE_WIDTH-1:0]              s_be_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  input  logic [DATA_WIDTH-1:0]            s_rdata_i,
  input  logic                             s_err_i,
  // status
  output logic                             spurious_rsp_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  // arbitration state
  logic [IDX_W-1:0] rr_ptr;
  logic             lock_vld;
  logic [IDX_W-1:0] lock_idx;

  // routing FIFO state: holds the master index of every accepted, unanswered transaction
  logic [IDX_W-1:0] fifo_dat [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] winner;
  logic             lock_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             pop;
  logic [IDX_W-1:0] head_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping around the master set.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_MASTERS;
      if (!arb_found && m_req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  // A stalled request keeps its owner; a locked master that drops req simply blocks the bus for a cycle.
  assign winner     = lock_vld ? lock_idx : arb_idx;
  assign lock_ok    = !lock_vld || m_req_i[lock_idx];
  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);

  // Full is judged on the registered count, so a same-cycle pop never lets a new request through.
  assign s_req_o    = rst_ni && (|m_req_i) && lock_ok && !fifo_full;
  assign accept     = s_req_o && s_gnt_i;

  // Route the winner's request fields to the slave.
  always_comb begin
    s_we_o    = m_we_i[winner];
    s_be_o    = m_be_i[int'(winner)*BE_WIDTH +: BE_WIDTH];
    s_addr_o  = m_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    s_wdata_o = m_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Grant only the winner, and only in the cycle the slave accepts.
  always_comb begin
    m_gnt_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (accept && (winner == IDX_W'(i))) begin
        m_gnt_o[i] = 1'b1;
      end
    end
  end

  // Responses go to the oldest outstanding entry; data and error are shared and pass straight through.
  assign head_idx       = fifo_dat[rd_ptr];
  assign pop            = s_rvalid_i && !fifo_empty;
  assign spurious_rsp_o = rst_ni && s_rvalid_i && fifo_empty;
  assign m_rdata_o      = s_rdata_i;
  assign m_err_o        = s_err_i;

  // Steer the response valid to the head master.
  always_comb begin
    m_rvalid_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pop && (head_idx == IDX_W'(i))) begin
        m_rvalid_o[i] = 1'b1;
      end
    end
  end

  // Round-robin pointer moves past the master just served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + IDX_W'(1);
    end
  end

  // Lock holds a stalled winner until granted, or until it withdraws its request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else if (s_req_o && !s_gnt_i) begin
      lock_vld <= 1'b1;
      lock_idx <= winner;
    end else if (accept) begin
      lock_vld <= 1'b0;
    end else if (lock_vld && !m_req_i[lock_idx]) begin
      lock_vld <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_dat[wr_ptr] <= winner;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
module tb_ibex_mem_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [NM-1:0]    m_req_i;
  logic [NM-1:0]    m_gnt_o;
  logic [NM-1:0]    m_rvalid_o;
  logic [NM-1:0]    m_we_i;
  logic [NM*BW-1:0] m_be_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_wdata_i;
  logic [DW-1:0]    m_rdata_o;
  logic             m_err_o;
  logic             s_req_o;
  logic             s_gnt_i;
  logic             s_rvalid_i;
  logic             s_we_o;
  logic [BW-1:0]    s_be_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_wdata_o;
  logic [DW-1:0]    s_rdata_i;
  logic             s_err_i;
  logic             spurious_rsp_o;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk_i = ~clk_i;

  ibex_mem_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_err_i(s_err_i), .spurious_rsp_o(spurious_rsp_o)
  );

  // per-master request fields, fixed for the whole run
  function automatic logic [AW-1:0] addr_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h0001_0100;
  endfunction
  function automatic logic [DW-1:0] wdata_of(input int k);
    return 32'hA5A5_0000 + 32'(k) * 32'h0000_1111;
  endfunction
  function automatic logic [BW-1:0] be_of(input int k);
    return (k == 0) ? 4'hF : 4'h3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at posedge+1, check combinational outputs at the negedge,
  // pop the scoreboard on responses and push it on expected grants.
  task automatic cyc(input string tag, input logic [NM-1:0] req, input logic gnt,
                     input logic rv, input logic exp_sreq, input int exp_win);
    logic [DW-1:0] rd;
    logic          er;
    int            k;
    rd = $urandom;
    er = 1'($urandom_range(0, 1));
    m_req_i    = req;
    s_gnt_i    = gnt;
    s_rvalid_i = rv;
    s_rdata_i  = rd;
    s_err_i    = er;
    #4;
    check({tag, ".sreq"}, 64'(s_req_o), 64'(exp_sreq));
    if (exp_sreq) begin
      check({tag, ".addr"},  64'(s_addr_o),  64'(addr_of(exp_win)));
      check({tag, ".wdata"}, 64'(s_wdata_o), 64'(wdata_of(exp_win)));
      check({tag, ".be"},    64'(s_be_o),    64'(be_of(exp_win)));
      check({tag, ".we"},    64'(s_we_o),    64'(exp_win == 1));
    end
    check({tag, ".gnt"}, 64'(m_gnt_o), (exp_sreq && gnt) ? (64'd1 << exp_win) : 64'd0);
    if (rv && exp_q.size() > 0) begin
      k = exp_q.pop_front();
      check({tag, ".rvalid"}, 64'(m_rvalid_o), 64'd1 << k);
      check({tag, ".rdata"},  64'(m_rdata_o),  64'(rd));
      check({tag, ".err"},    64'(m_err_o),    64'(er));
      check({tag, ".spur"},   64'(spurious_rsp_o), 64'd0);
    end else begin
      check({tag, ".rvalid"}, 64'(m_rvalid_o), 64'd0);
      check({tag, ".spur"},   64'(spurious_rsp_o), 64'(rv));
    end
    if (exp_sreq && gnt) exp_q.push_back(exp_win);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int k = 0; k < NM; k++) begin
      m_addr_i[k*AW +: AW]  = addr_of(k);
      m_wdata_i[k*DW +: DW] = wdata_of(k);
      m_be_i[k*BW +: BW]    = be_of(k);
      m_we_i[k]             = (k == 1);
    end
    // reset: outputs must be quiet even with requests and a response pending
    rst_ni     = 1'b0;
    m_req_i    = 2'b11;
    s_gnt_i    = 1'b1;
    s_rvalid_i = 1'b1;
    s_rdata_i  = '0;
    s_err_i    = 1'b0;
    #3;
    check("reset.sreq",   64'(s_req_o),        64'd0);
    check("reset.gnt",    64'(m_gnt_o),        64'd0);
    check("reset.rvalid", 64'(m_rvalid_o),     64'd0);
    check("reset.spur",   64'(spurious_rsp_o), 64'd0);
    m_req_i    = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // single master: same-cycle grant, response next cycle, pointer moves to 1
    cyc("single",     2'b01, 1'b1, 1'b0, 1'b1, 0);
    cyc("single_rsp", 2'b00, 1'b0, 1'b1, 1'b0, 0);

    // fairness: pointer is 1, so grants go 10,01,10,01 with one response per cycle
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("fair%0d", i), 2'b11, 1'b1, (i > 0), 1'b1, (i % 2 == 0) ? 1 : 0);
    end
    cyc("fair_drain", 2'b00, 1'b0, 1'b1, 1'b0, 0);

    // move the pointer to 0 so master 0 would win without the lock
    cyc("prelock",     2'b10, 1'b1, 1'b0, 1'b1, 1);
    cyc("prelock_rsp", 2'b00, 1'b0, 1'b1, 1'b0, 0);

    // lock: master 1 stalls three cycles while master 0 joins, granted on cycle 4
    cyc("lock0", 2'b10, 1'b0, 1'b0, 1'b1, 1);
    cyc("lock1", 2'b11, 1'b0, 1'b0, 1'b1, 1);
    cyc("lock2", 2'b11, 1'b0, 1'b0, 1'b1, 1);
    cyc("lock3", 2'b11, 1'b1, 1'b0, 1'b1, 1);
    cyc("after_lock", 2'b01, 1'b1, 1'b1, 1'b1, 0);
    cyc("lock_drain", 2'b00, 1'b0, 1'b1, 1'b0, 0);

    // full backpressure, then same-cycle accept and response at count 1
    cyc("full_a", 2'b10, 1'b1, 1'b0, 1'b1, 1);
    cyc("full_b", 2'b01, 1'b1, 1'b0, 1'b1, 0);
    cyc("full_c", 2'b01, 1'b1, 1'b0, 1'b0, 0);
    cyc("full_d", 2'b11, 1'b1, 1'b1, 1'b0, 0);
    cyc("full_e", 2'b10, 1'b1, 1'b1, 1'b1, 1);
    cyc("full_f", 2'b00, 1'b0, 1'b1, 1'b0, 0);

    // locked master withdraws: bus idles one cycle, then the other master proceeds
    cyc("ldrop0", 2'b10, 1'b0, 1'b0, 1'b1, 1);
    cyc("ldrop1", 2'b01, 1'b0, 1'b0, 1'b0, 0);
    cyc("ldrop2", 2'b01, 1'b1, 1'b0, 1'b1, 0);
    cyc("ldrop_rsp", 2'b00, 1'b0, 1'b1, 1'b0, 0);

    // response with nothing outstanding
    cyc("spur", 2'b00, 1'b0, 1'b1, 1'b0, 0);

    // reset mid-operation with two outstanding, pointer left at 1
    cyc("rst_a", 2'b10, 1'b1, 1'b0, 1'b1, 1);
    cyc("rst_b", 2'b01, 1'b1, 1'b0, 1'b1, 0);
    m_req_i    = 2'b11;
    s_gnt_i    = 1'b1;
    s_rvalid_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    check("midrst.sreq",   64'(s_req_o),        64'd0);
    check("midrst.gnt",    64'(m_gnt_o),        64'd0);
    check("midrst.rvalid", 64'(m_rvalid_o),     64'd0);
    check("midrst.spur",   64'(spurious_rsp_o), 64'd0);
    exp_q.delete();
    m_req_i    = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    cyc("post_rst_spur", 2'b00, 1'b0, 1'b1, 1'b0, 0);
    cyc("post_rst_rr",   2'b11, 1'b1, 1'b0, 1'b1, 0);
    cyc("post_rst_rsp",  2'b00, 1'b0, 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
